// File: rtl/path_replay.sv
// Direction stack for the maze solver: records forward steps during search,
// pops on backtrack, and replays the stored path oldest-first over ready/valid.
module path_replay #(
    parameter int         DEPTH     = 256,
    parameter int         AW        = 8,
    parameter logic [7:0] START_LOC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] dirIn,
    input  logic       run,
    input  logic       ready,
    output logic       empStck,
    output logic       full,
    output logic       overflow,
    output logic       move,
    output logic [1:0] dir,
    output logic [7:0] loc,
    output logic       replayDone
);

    localparam int SPW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPLAY = 2'd1,
        FIN    = 2'd2
    } state_t;

    logic [1:0]     mem_q [DEPTH];

    state_t         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [AW-1:0]  rp_q, rp_d;
    logic [7:0]     loc_q, loc_d;
    logic           ovf_q, ovf_d;
    logic           move_q, move_d;
    logic [1:0]     dir_q, dir_d;
    logic           done_q, done_d;

    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [SPW-1:0] sp_dec;
    logic [AW-1:0]  rp_inc;
    logic           last_beat;

    // Each nibble steps independently and wraps modulo 16.
    function automatic logic [7:0] step_loc(input logic [7:0] l, input logic [1:0] d);
        logic [3:0] x;
        logic [3:0] y;
        x = l[3:0];
        y = l[7:4];
        case (d)
            2'd0:    x = x + 4'd1;
            2'd1:    y = y + 4'd1;
            2'd2:    x = x - 4'd1;
            default: y = y - 4'd1;
        endcase
        return {y, x};
    endfunction

    assign empStck    = (sp_q == '0);
    assign full       = (sp_q == SPW'(DEPTH));
    assign overflow   = ovf_q;
    assign move       = move_q;
    assign dir        = dir_q;
    assign loc        = loc_q;
    assign replayDone = done_q;

    assign sp_dec    = sp_q - SPW'(1);
    assign rp_inc    = rp_q + AW'(1);
    assign last_beat = ({1'b0, rp_q} == sp_dec);

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        rp_d    = rp_q;
        loc_d   = loc_q;
        ovf_d   = ovf_q;
        move_d  = move_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = sp_q[AW-1:0];

        case (state_q)
            IDLE: begin
                // Push with pop on a non-empty stack rewrites the top in place.
                if (push && (!pop || empStck)) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = sp_q[AW-1:0];
                        sp_d    = sp_q + SPW'(1);
                    end
                end else if (push && pop) begin
                    wr_en   = 1'b1;
                    wr_addr = sp_dec[AW-1:0];
                end else if (pop && !empStck) begin
                    sp_d = sp_dec;
                end

                if (run) begin
                    rp_d  = '0;
                    loc_d = START_LOC;
                    if (!empStck) begin
                        state_d = REPLAY;
                        move_d  = 1'b1;
                        dir_d   = mem_q[0];
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end

            REPLAY: begin
                if (ready) begin
                    loc_d = step_loc(loc_q, dir_q);
                    rp_d  = rp_inc;
                    if (last_beat) begin
                        state_d = FIN;
                        move_d  = 1'b0;
                        dir_d   = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        dir_d = mem_q[rp_inc];
                    end
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                move_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sp_q    <= '0;
            rp_q    <= '0;
            loc_q   <= START_LOC;
            ovf_q   <= 1'b0;
            move_q  <= 1'b0;
            dir_q   <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            rp_q    <= rp_d;
            loc_q   <= loc_d;
            ovf_q   <= ovf_d;
            move_q  <= move_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_addr] <= dirIn;
        end
    end

endmodule
